// File: rtl/matmul_ctrl.sv
// Control FSM for the matrix-multiply datapath: loads A (m x n) and B (n x m) from a word stream,
// then sequences C = A*B one element at a time (clear, n MACs, drain, write).
module matmul_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned m          = 8,
    parameter int unsigned n          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             m1EN,
    output logic             m1rEN,
    output logic             m1wEN,
    output logic             m2EN,
    output logic             m2rEN,
    output logic             m2wEN,
    output logic             m3EN,
    output logic             m3rEN,
    output logic             m3wEN,
    output logic             mult_ld,
    output logic             mult_rst,
    output logic [m+n-1:0]   addr1,
    output logic [m+n-1:0]   addr2,
    output logic [m+n-1:0]   addr3,
    output logic [1:0]       shift_cnt
);

    // DATA_WIDTH only mirrors the datapath parameter list; it has no effect here.
    localparam int unsigned AW = m + n + 0 * DATA_WIDTH;

    localparam logic [AW-1:0] LastLd = AW'(m * n - 1);
    localparam logic [AW-1:0] LastK  = AW'(n - 1);
    localparam logic [AW-1:0] LastIj = AW'(m - 1);
    localparam logic [AW-1:0] MAw    = AW'(m);
    localparam logic [AW-1:0] NAw    = AW'(n);

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StClr, StMac, StDrain, StWrite, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   lc_q, lc_d;
    logic [AW-1:0]   i_q, i_d;
    logic [AW-1:0]   j_q, j_d;
    logic [AW-1:0]   k_q, k_d;
    logic            pv_q, pv_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lc_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            pv_q    <= pv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        pv_d    = pv_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadA;
                    lc_d    = '0;
                end
            end
            StLoadA: begin
                if (in_valid) begin
                    if (lc_q == LastLd) begin
                        lc_d    = '0;
                        state_d = StLoadB;
                    end else begin
                        lc_d = lc_q + 1'b1;
                    end
                end
            end
            StLoadB: begin
                if (in_valid) begin
                    if (lc_q == LastLd) begin
                        lc_d    = '0;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = StClr;
                    end else begin
                        lc_d = lc_q + 1'b1;
                    end
                end
            end
            StClr: begin
                k_d     = '0;
                state_d = StMac;
            end
            StMac: begin
                pv_d = 1'b1;
                if (k_q == LastK) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                pv_d    = 1'b0;
                state_d = StWrite;
            end
            StWrite: begin
                if (j_q == LastIj) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                state_d = (i_q == LastIj && j_q == LastIj) ? StDone : StClr;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        m1EN      = 1'b0;
        m1rEN     = 1'b0;
        m1wEN     = 1'b0;
        m2EN      = 1'b0;
        m2rEN     = 1'b0;
        m2wEN     = 1'b0;
        m3EN      = 1'b0;
        m3rEN     = 1'b0;
        m3wEN     = 1'b0;
        mult_ld   = 1'b0;
        mult_rst  = 1'b0;
        addr1     = '0;
        addr2     = '0;
        addr3     = '0;
        shift_cnt = 2'b00;
        unique case (state_q)
            StLoadA: begin
                in_ready = 1'b1;
                addr1    = lc_q;
                m1EN     = in_valid;
                m1wEN    = in_valid;
            end
            StLoadB: begin
                in_ready = 1'b1;
                addr2    = lc_q;
                m2EN     = in_valid;
                m2wEN    = in_valid;
            end
            StClr: mult_rst = 1'b1;
            StMac: begin
                m1EN    = 1'b1;
                m1rEN   = 1'b1;
                m2EN    = 1'b1;
                m2rEN   = 1'b1;
                addr1   = i_q * NAw + k_q;
                addr2   = k_q * MAw + j_q;
                // Accumulate the product whose read was issued last cycle.
                mult_ld = pv_q;
            end
            StDrain: mult_ld = 1'b1;
            StWrite: begin
                m3EN  = 1'b1;
                m3wEN = 1'b1;
                addr3 = i_q * MAw + j_q;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: a 2x2 instance drives a small datapath model,
// a 3x3 instance is used to check the MAC address sequence of one element.
module tb_matmul_ctrl;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2x2 instance
    logic       a_start, a_in_valid;
    logic       a_in_ready, a_busy, a_done;
    logic       a_m1EN, a_m1rEN, a_m1wEN, a_m2EN, a_m2rEN, a_m2wEN, a_m3EN, a_m3rEN, a_m3wEN;
    logic       a_mult_ld, a_mult_rst;
    logic [3:0] a_addr1, a_addr2, a_addr3;
    logic [1:0] a_shift_cnt;

    // 3x3 instance
    logic       b_start, b_in_valid;
    logic       b_in_ready, b_busy, b_done;
    logic       b_m1EN, b_m1rEN, b_m1wEN, b_m2EN, b_m2rEN, b_m2wEN, b_m3EN, b_m3rEN, b_m3wEN;
    logic       b_mult_ld, b_mult_rst;
    logic [5:0] b_addr1, b_addr2, b_addr3;
    logic [1:0] b_shift_cnt;

    matmul_ctrl #(.DATA_WIDTH(8), .m(2), .n(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .busy(a_busy), .done(a_done),
        .m1EN(a_m1EN), .m1rEN(a_m1rEN), .m1wEN(a_m1wEN),
        .m2EN(a_m2EN), .m2rEN(a_m2rEN), .m2wEN(a_m2wEN),
        .m3EN(a_m3EN), .m3rEN(a_m3rEN), .m3wEN(a_m3wEN),
        .mult_ld(a_mult_ld), .mult_rst(a_mult_rst),
        .addr1(a_addr1), .addr2(a_addr2), .addr3(a_addr3), .shift_cnt(a_shift_cnt)
    );

    matmul_ctrl #(.DATA_WIDTH(8), .m(3), .n(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .busy(b_busy), .done(b_done),
        .m1EN(b_m1EN), .m1rEN(b_m1rEN), .m1wEN(b_m1wEN),
        .m2EN(b_m2EN), .m2rEN(b_m2rEN), .m2wEN(b_m2wEN),
        .m3EN(b_m3EN), .m3rEN(b_m3rEN), .m3wEN(b_m3wEN),
        .mult_ld(b_mult_ld), .mult_rst(b_mult_rst),
        .addr1(b_addr1), .addr2(b_addr2), .addr3(b_addr3), .shift_cnt(b_shift_cnt)
    );

    // Datapath model for the 2x2 instance: synchronous-read memories and accumulator.
    logic [7:0]  data_in;
    logic [7:0]  mem_a [4];
    logic [7:0]  mem_b [4];
    logic [15:0] mem_c [4];
    logic [7:0]  rd_a, rd_b;
    logic [15:0] acc;

    always @(posedge clk) begin
        if (a_m1EN && a_m1wEN) mem_a[a_addr1[1:0]] <= data_in;
        if (a_m1EN && a_m1rEN) rd_a <= mem_a[a_addr1[1:0]];
        if (a_m2EN && a_m2wEN) mem_b[a_addr2[1:0]] <= data_in;
        if (a_m2EN && a_m2rEN) rd_b <= mem_b[a_addr2[1:0]];
        if (a_mult_rst)      acc <= 16'd0;
        else if (a_mult_ld)  acc <= acc + 16'(rd_a) * 16'(rd_b);
        if (a_m3EN && a_m3wEN) mem_c[a_addr3[1:0]] <= acc;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int a_outs();
        return int'({a_in_ready, a_busy, a_done, a_m1EN, a_m1rEN, a_m1wEN, a_m2EN, a_m2rEN,
                     a_m2wEN, a_m3EN, a_m3rEN, a_m3wEN, a_mult_ld, a_mult_rst, a_addr1,
                     a_addr2, a_addr3, a_shift_cnt});
    endfunction

    function automatic int b_any();
        return int'(|{b_in_ready, b_busy, b_done, b_m1EN, b_m1rEN, b_m1wEN, b_m2EN, b_m2rEN,
                      b_m2wEN, b_m3EN, b_m3rEN, b_m3wEN, b_mult_ld, b_mult_rst, b_addr1,
                      b_addr2, b_addr3, b_shift_cnt});
    endfunction

    task automatic a_begin();
        @(negedge clk);
        a_start = 1'b1;
        #1;
        check("idle_busy", int'(a_busy), 0);
    endtask

    task automatic a_send(input bit to_b, input int adr, input int data);
        @(negedge clk);
        a_start    = 1'b0;
        a_in_valid = 1'b1;
        data_in    = 8'(data);
        #1;
        check("ld_ready", int'(a_in_ready), 1);
        if (to_b) begin
            check("ldB_wen", int'(a_m2EN & a_m2wEN), 1);
            check("ldB_addr", int'(a_addr2), adr);
            check("ldB_other", int'(a_m1wEN), 0);
        end else begin
            check("ldA_wen", int'(a_m1EN & a_m1wEN), 1);
            check("ldA_addr", int'(a_addr1), adr);
            check("ldA_other", int'(a_m2wEN), 0);
        end
    endtask

    task automatic a_stall();
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        check("stall_wen", int'(a_m1wEN | a_m2wEN), 0);
        check("stall_ready", int'(a_in_ready), 1);
    endtask

    task automatic a_load(input bit stalled, input int v[8]);
        for (int w = 0; w < 8; w++) begin
            a_send(w >= 4, w % 4, v[w]);
            if (stalled && w < 7) a_stall();
        end
    endtask

    // Counts cycles after the last load word until done; checks per-cycle exclusivity.
    task automatic a_wait_done(input int exp);
        bit got  = 1'b0;
        int viol = 0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) begin
                check("clr_ready", int'(a_in_ready), 0);
                check("clr_rst", int'(a_mult_rst), 1);
            end
            if (a_mult_rst && a_mult_ld) viol++;
            if (a_m1wEN || a_m2wEN) viol++;
            if (a_m3rEN) viol++;
            if (a_done) begin
                got = 1'b1;
                check("done_lat", c, exp);
            end
        end
        if (!got) check("done_seen", 0, 1);
        check("compute_excl", viol, 0);
    endtask

    task automatic a_check_c(input int c0, input int c1, input int c2, input int c3);
        check("c0", int'(mem_c[0]), c0);
        check("c1", int'(mem_c[1]), c1);
        check("c2", int'(mem_c[2]), c2);
        check("c3", int'(mem_c[3]), c3);
    endtask

    int v1[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int v2[8] = '{2, 0, 1, 1, 1, 3, 2, 4};

    initial begin
        rst        = 1'b1;
        a_start    = 1'b0;
        a_in_valid = 1'b0;
        b_start    = 1'b0;
        b_in_valid = 1'b0;
        data_in    = 8'd0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_outs_a", a_outs(), 0);
        check("rst_outs_b", b_any(), 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rel_busy", int'(a_busy), 0);

        // Job 1: back-to-back load, full compute, in_valid left high during compute
        a_begin();
        a_load(1'b0, v1);
        a_wait_done(21);
        a_check_c(19, 22, 43, 50);
        a_start = 1'b1;
        @(negedge clk);
        #1;
        check("done_pulse", int'(a_done), 0);
        check("done_to_idle", int'(a_busy), 0);

        // Job 2: start was held through DONE; stalled load with a different matrix pair
        a_load(1'b1, v2);
        a_wait_done(21);
        a_check_c(2, 6, 3, 7);

        // Job 3: abort during MAC, then a clean rerun
        a_begin();
        a_load(1'b0, v1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_outs", a_outs(), 0);
        a_begin();
        a_load(1'b0, v1);
        a_wait_done(21);
        a_check_c(19, 22, 43, 50);

        // 3x3 instance: MAC sequence of element (1,2)
        @(negedge clk);
        b_start = 1'b1;
        #1;
        check("b_idle_busy", int'(b_busy), 0);
        for (int w = 0; w < 18; w++) begin
            @(negedge clk);
            b_start    = 1'b0;
            b_in_valid = 1'b1;
            #1;
            if (w == 17) begin
                check("b_last_wen", int'(b_m2wEN), 1);
                check("b_last_addr", int'(b_addr2), 8);
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        repeat (29) @(negedge clk);
        @(negedge clk);
        #1;
        check("b_clr", int'(b_mult_rst), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("b_rd", int'(b_m1rEN & b_m2rEN), 1);
            check("b_addr1", int'(b_addr1), 3 + c);
            check("b_addr2", int'(b_addr2), 2 + 3 * c);
            check("b_mult_ld", int'(b_mult_ld), (c > 0) ? 1 : 0);
        end
        @(negedge clk);
        #1;
        check("b_drain_ld", int'(b_mult_ld), 1);
        check("b_drain_rd", int'(b_m1rEN | b_m2rEN), 0);
        @(negedge clk);
        #1;
        check("b_wr", int'(b_m3wEN), 1);
        check("b_addr3", int'(b_addr3), 5);
        begin
            bit got = 1'b0;
            for (int c = 1; c <= 100 && !got; c++) begin
                @(negedge clk);
                #1;
                if (b_done) begin
                    got = 1'b1;
                    check("b_done_lat", c, 19);
                end
            end
            if (!got) check("b_done_seen", 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
